mc_control_fsm: RTL and testbench

//  Main control unit of the multicycle RISC-V core; produces the 16-bit Control_word consumed by Data_Path.

---
 rtl/mc_control_fsm.sv | 176 +++++++++++++++++
 tb/tb_mc_control_fsm.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
//   Main control unit of the multicycle RISC-V core. A Moore FSM steps each
//   instruction through FETCH / DECODE / EXECUTE / MEM / WRITEBACK, using the
//   IR opcode to choose a path. It drives the 16-bit Control_word consumed
//   unchanged by Data_Path. mem_ready stretches the memory states: FETCH,
//   MEMRD and MEMWR wait until the memory completes its access.
//
//   Control_word bit map:
//     [15] PCWrite   [14] PCWriteCond [13] IorD      [12] MemRead
//     [11] MemWrite  [10] IRWrite     [9]  MemtoReg  [8:7] PCSource
//     [6:5] ALUOp    [4:3] ALUSrcB    [2]  ALUSrcA   [1]  RegWrite
//     [0]  RegDst
//
//   Optional feature macro: MC_TRAP_EN
//     Defined   : an unknown opcode in DECODE enters HALT and sets the
//                 sticky 'illegal' flag. Only reset leaves HALT.
//     Undefined : an unknown opcode is treated as a NOP and the FSM returns
//                 to FETCH. 'illegal' is tied low.
// ---------------------------------------------------------------------------
module mc_control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  Opcode,
  input  logic        mem_ready,
  output logic [15:0] Control_word,
  output logic [3:0]  state,
  output logic        illegal
);

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_BR    = 7'h63;

  // Per-state control words. FETCH has a second form that it drives while
  // it waits for memory: PCWrite and IRWrite are dropped, so the PC and the
  // IR do not change until the fetched word is actually available.
  localparam logic [15:0] CW_FETCH      = 16'h9408;
  localparam logic [15:0] CW_FETCH_WAIT = 16'h1008;
  localparam logic [15:0] CW_DECODE     = 16'h0018;
  localparam logic [15:0] CW_MEMADR     = 16'h0014;
  localparam logic [15:0] CW_MEMRD      = 16'h3000;
  localparam logic [15:0] CW_MEMWB      = 16'h0202;
  localparam logic [15:0] CW_MEMWR      = 16'h2800;
  localparam logic [15:0] CW_EXEC_R     = 16'h0044;
  localparam logic [15:0] CW_EXEC_I     = 16'h0074;
  localparam logic [15:0] CW_RWB        = 16'h0003;
  localparam logic [15:0] CW_BRANCH     = 16'h40A4;
  localparam logic [15:0] CW_IDLE       = 16'h0000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_HALT   = 4'd10
  } state_e;

  state_e state_q, state_d;

  // State register: reset is synchronous, so every state returns to FETCH
  // on the next rising edge while reset is high.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking (<=) assignments so that every
    // flop samples its value from before the edge, whatever order the
    // processes run in.
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state decode and Moore outputs. Control_word depends only on the
  // current state and mem_ready, never on Opcode.
  always_comb begin
    // NOTE: both outputs get a default before the case statement, so no
    // path leaves them unassigned and no latch is inferred.
    state_d      = S_FETCH;
    Control_word = CW_IDLE;
    unique case (state_q)
      S_FETCH: begin
        Control_word = mem_ready ? CW_FETCH : CW_FETCH_WAIT;
        state_d      = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        Control_word = CW_DECODE;
        if (Opcode == OP_LOAD || Opcode == OP_STORE) state_d = S_MEMADR;
        else if (Opcode == OP_R)                     state_d = S_EXEC_R;
        else if (Opcode == OP_I)                     state_d = S_EXEC_I;
        else if (Opcode == OP_BR)                    state_d = S_BRANCH;
        else begin
`ifdef MC_TRAP_EN
          state_d = S_HALT;
`else
          // Unknown opcode acts as a NOP: the PC was already advanced in FETCH.
          state_d = S_FETCH;
`endif
        end
      end
      S_MEMADR: begin
        // The IR holds Opcode stable, so it is decoded a second time here
        // to choose between the load path and the store path.
        Control_word = CW_MEMADR;
        if (Opcode == OP_LOAD)       state_d = S_MEMRD;
        else if (Opcode == OP_STORE) state_d = S_MEMWR;
        else                         state_d = S_FETCH;
      end
      S_MEMRD: begin
        Control_word = CW_MEMRD;
        state_d      = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        Control_word = CW_MEMWB;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        // MemWrite stays high for every cycle until memory accepts the write.
        Control_word = CW_MEMWR;
        state_d      = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC_R: begin
        Control_word = CW_EXEC_R;
        state_d      = S_RWB;
      end
      S_EXEC_I: begin
        Control_word = CW_EXEC_I;
        state_d      = S_RWB;
      end
      S_RWB: begin
        Control_word = CW_RWB;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        Control_word = CW_BRANCH;
        state_d      = S_FETCH;
      end
      S_HALT: begin
        Control_word = CW_IDLE;
`ifdef MC_TRAP_EN
        state_d = S_HALT;
`else
        state_d = S_FETCH;
`endif
      end
      default: begin
        // Codes 11-15 are unused. Recover to FETCH with every strobe off.
        Control_word = CW_IDLE;
        state_d      = S_FETCH;
      end
    endcase
  end

  assign state = state_q;

`ifdef MC_TRAP_EN
  logic illegal_q;

  // Sticky illegal-opcode flag. It is set on the DECODE->HALT transition
  // and only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)                                           illegal_q <= 1'b0;
    else if (state_q == S_DECODE && state_d == S_HALT)   illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_control_fsm
//   Self-checking bench for mc_control_fsm. Each instruction class is modelled
//   as a list of steps (state code, control word, wait-gated word, waits on
//   mem_ready). The model walks this list under random or patterned
//   mem_ready and compares the DUT with it on every cycle. The trap build is
//   selected by MC_TRAP_EN, exactly as in the RTL.
// ---------------------------------------------------------------------------
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  Opcode;
  logic        mem_ready;
  logic [15:0] Control_word;
  logic [3:0]  state;
  logic        illegal;

  int vectors = 0;
  int errors  = 0;

  typedef struct packed {
    logic [3:0]  code;
    logic [15:0] cw;
    logic [15:0] cw_wait;
    logic        waits;
  } step_t;

  mc_control_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .Opcode       (Opcode),
    .mem_ready    (mem_ready),
    .Control_word (Control_word),
    .state        (state),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  function automatic step_t mk(input logic [3:0] c, input logic [15:0] w,
                               input logic [15:0] ww, input logic wt);
    step_t s;
    s.code = c; s.cw = w; s.cw_wait = ww; s.waits = wt;
    return s;
  endfunction

  function automatic bit is_known(input logic [6:0] op);
    return op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 || op == 7'h63;
  endfunction

  function automatic logic [6:0] rand_opcode();
    logic [6:0] op;
    case ($urandom_range(0, 5))
      0: op = 7'h33;
      1: op = 7'h13;
      2: op = 7'h03;
      3: op = 7'h23;
      4: op = 7'h63;
      default: begin
        op = 7'($urandom_range(0, 127));
        while (is_known(op)) op = 7'($urandom_range(0, 127));
      end
    endcase
    return op;
  endfunction

  // Assert reset for one rising edge. On return the DUT is in its first
  // post-reset cycle, 1 time unit after the edge.
  task automatic apply_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Run one instruction from FETCH. The caller must already be in FETCH.
  task automatic run_instr(input logic [6:0] op, input bit use_pat, input logic [31:0] pat);
    step_t steps[$];
    step_t cur;
    logic [15:0] exp_cw;
    logic mr;
    int k, cycles, mw_seen, mw_exp;
    bit unknown;

    unknown = !is_known(op);
    steps.push_back(mk(4'd0, 16'h9408, 16'h1008, 1'b1));
    steps.push_back(mk(4'd1, 16'h0018, 16'h0018, 1'b0));
    case (op)
      7'h33: begin
        steps.push_back(mk(4'd6, 16'h0044, 16'h0044, 1'b0));
        steps.push_back(mk(4'd8, 16'h0003, 16'h0003, 1'b0));
      end
      7'h13: begin
        steps.push_back(mk(4'd7, 16'h0074, 16'h0074, 1'b0));
        steps.push_back(mk(4'd8, 16'h0003, 16'h0003, 1'b0));
      end
      7'h03: begin
        steps.push_back(mk(4'd2, 16'h0014, 16'h0014, 1'b0));
        steps.push_back(mk(4'd3, 16'h3000, 16'h3000, 1'b1));
        steps.push_back(mk(4'd4, 16'h0202, 16'h0202, 1'b0));
      end
      7'h23: begin
        steps.push_back(mk(4'd2, 16'h0014, 16'h0014, 1'b0));
        steps.push_back(mk(4'd5, 16'h2800, 16'h2800, 1'b1));
      end
      7'h63: steps.push_back(mk(4'd9, 16'h40A4, 16'h40A4, 1'b0));
      default: ;
    endcase

    Opcode = op;
    k = 0; cycles = 0; mw_seen = 0; mw_exp = 0;
    while (k < steps.size() && cycles < 64) begin
      cur = steps[k];
      mr  = use_pat ? pat[cycles & 31] : ($urandom_range(0, 3) != 0);
      mem_ready = mr;
      #1;
      exp_cw = (cur.waits && !mr) ? cur.cw_wait : cur.cw;
      vectors++;
      if (state !== cur.code || Control_word !== exp_cw || illegal !== 1'b0) begin
        errors++;
        $display("FAIL seq op=%h cyc=%0d: state=%0d cw=%h ill=%b, want state=%0d cw=%h ill=0",
                 op, cycles, state, Control_word, illegal, cur.code, exp_cw);
      end
      if (cur.code == 4'd5) mw_exp++;
      if (Control_word[11]) mw_seen++;
      if (!(cur.waits && !mr)) k++;
      cycles++;
      @(posedge clk); #1;
    end
    if (cycles >= 64) begin
      errors++;
      $display("FAIL timeout op=%h: model did not complete", op);
    end

    vectors++;
    if (mw_seen != mw_exp) begin
      errors++;
      $display("FAIL memwrite_cycles op=%h: got %0d, want %0d", op, mw_seen, mw_exp);
    end

    mem_ready = 1'b1;
    #1;
`ifdef MC_TRAP_EN
    if (unknown) begin
      for (int i = 0; i < 3; i++) begin
        mem_ready = ($urandom_range(0, 1) != 0);
        #1;
        vectors++;
        if (state !== 4'd10 || Control_word !== 16'h0000 || illegal !== 1'b1) begin
          errors++;
          $display("FAIL halt op=%h: state=%0d cw=%h ill=%b, want state=10 cw=0000 ill=1",
                   op, state, Control_word, illegal);
        end
        @(posedge clk); #1;
      end
      apply_reset();
      #1;
      vectors++;
      if (state !== 4'd0 || illegal !== 1'b0 || Control_word !== 16'h9408) begin
        errors++;
        $display("FAIL halt_reset: state=%0d ill=%b cw=%h, want state=0 ill=0 cw=9408",
                 state, illegal, Control_word);
      end
      return;
    end
`endif
    // The instruction is done: the DUT must be back in FETCH with no flag.
    vectors++;
    if (state !== 4'd0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL end_state op=%h: state=%0d ill=%b, want state=0 ill=0",
               op, state, illegal);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    mem_ready = 1'b1; #1;
    vectors++;
    if (state !== 4'd0 || Control_word !== 16'h9408 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: state=%0d cw=%h ill=%b, want 0 9408 0", state, Control_word, illegal);
    end
    mem_ready = 1'b0; #1;
    vectors++;
    if (Control_word !== 16'h1008) begin
      errors++;
      $display("FAIL reset_wait_cw: cw=%h, want 1008", Control_word);
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (state !== 4'd1 || Control_word !== 16'h0018) begin
      errors++;
      $display("FAIL reset_next: state=%0d cw=%h, want 1 0018", state, Control_word);
    end
    apply_reset();
  endtask

  task automatic test_r_type();
    run_instr(7'h33, 1'b1, 32'hFFFF_FFFF);
    run_instr(7'h13, 1'b1, 32'hFFFF_FFFF);
  endtask

  task automatic test_load_wait();
    run_instr(7'h03, 1'b1, 32'hFFFF_FFE7);
  endtask

  task automatic test_store_wait();
    run_instr(7'h23, 1'b1, 32'hFFFF_FFFE);
    run_instr(7'h23, 1'b1, 32'hFFFF_FFCF);
  endtask

  task automatic test_illegal();
    run_instr(7'h7F, 1'b1, 32'hFFFF_FFFF);
    run_instr(7'h33, 1'b1, 32'hFFFF_FFFF);
  endtask

  task automatic test_reset_in_branch();
    Opcode = 7'h63;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++;
    if (state !== 4'd9 || Control_word !== 16'h40A4) begin
      errors++;
      $display("FAIL branch_state: state=%0d cw=%h, want 9 40A4", state, Control_word);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    vectors++;
    if (state !== 4'd0 || Control_word !== 16'h9408 || Control_word[14] !== 1'b0) begin
      errors++;
      $display("FAIL branch_reset: state=%0d cw=%h, want 0 9408", state, Control_word);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) run_instr(rand_opcode(), 1'b0, 32'h0);
  endtask

  task automatic test_reset_random();
    logic mr;
    for (int n = 0; n < 20; n++) begin
      Opcode = rand_opcode();
      for (int c = 0; c < int'($urandom_range(0, 6)); c++) begin
        mem_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
      mr = ($urandom_range(0, 1) != 0);
      mem_ready = mr;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      vectors++;
      if (state !== 4'd0 || illegal !== 1'b0 || Control_word !== (mr ? 16'h9408 : 16'h1008)) begin
        errors++;
        $display("FAIL mid_reset: state=%0d cw=%h ill=%b, want 0 %h 0",
                 state, Control_word, illegal, mr ? 16'h9408 : 16'h1008);
      end
      @(posedge clk); #1;
      apply_reset();
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b1;
    Opcode = 7'h00;
    @(posedge clk); #1;
    test_reset();
    test_r_type();
    test_load_wait();
    test_store_wait();
    test_illegal();
    test_reset_in_branch();
    test_random();
    test_reset_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
